// File: rtl/mod_addsub_serial.sv
// Limb-serial modular add/sub: result = (a op b) mod p, LIMB bits per cycle.
// Ports: clk, rst_n, in_valid/in_ready/op/a/b/p in, out_valid/out_ready/result
// out; err_range out when MOD_ADDSUB_RANGE_CHK_EN is defined.
module mod_addsub_serial #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic             err_range
`endif
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = $clog2(NLIMB + 1);
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_r;
  logic             c_r;
  logic             w_r;
  logic [WIDTH-1:0] a_r, b_r, p_r;
  logic [WIDTH-1:0] t_r, u_r;

  logic             accept;
  logic [LIMB-1:0]  a_l, b_l, p_l;
  logic [LIMB:0]    t_x, u_x;
  logic [WIDTH-1:0] a_sh, b_sh, p_sh;
  logic [WIDTH-1:0] t_nxt, u_nxt;
  logic             sel_u;

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign a_l = a_r[LIMB-1:0];
  assign b_l = b_r[LIMB-1:0];
  assign p_l = p_r[LIMB-1:0];

  // Both chains in LIMB+1 bits; the top bit is the carry or borrow.
  always_comb begin
    t_x = '0;
    u_x = '0;
    if (!op_r) begin
      t_x = {1'b0, a_l} + {1'b0, b_l}
          + {{LIMB{1'b0}}, c_r};
      u_x = {1'b0, t_x[LIMB-1:0]} - {1'b0, p_l}
          - {{LIMB{1'b0}}, w_r};
    end else begin
      t_x = {1'b0, a_l} - {1'b0, b_l}
          - {{LIMB{1'b0}}, c_r};
      u_x = {1'b0, t_x[LIMB-1:0]} + {1'b0, p_l}
          + {{LIMB{1'b0}}, w_r};
    end
  end

  // Add: a+b >= p when it overflowed or T-p did not borrow.
  // Sub: a < b exactly when the difference borrowed.
  assign sel_u = op_r ? t_x[LIMB]
                      : (t_x[LIMB] || !u_x[LIMB]);

  // Operands shift down, results fill from the top.
  generate
    if (NLIMB == 1) begin : g_one
      assign a_sh  = a_r;
      assign b_sh  = b_r;
      assign p_sh  = p_r;
      assign t_nxt = t_x[LIMB-1:0];
      assign u_nxt = u_x[LIMB-1:0];
    end else begin : g_many
      assign a_sh  = {{LIMB{1'b0}}, a_r[WIDTH-1:LIMB]};
      assign b_sh  = {{LIMB{1'b0}}, b_r[WIDTH-1:LIMB]};
      assign p_sh  = {{LIMB{1'b0}}, p_r[WIDTH-1:LIMB]};
      assign t_nxt = {t_x[LIMB-1:0], t_r[WIDTH-1:LIMB]};
      assign u_nxt = {u_x[LIMB-1:0], u_r[WIDTH-1:LIMB]};
    end
  endgenerate

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic          ra_r, rb_r;
  logic [LIMB:0] ra_x, rb_x;
  logic          bad;

  assign ra_x = {1'b0, a_l} - {1'b0, p_l}
              - {{LIMB{1'b0}}, ra_r};
  assign rb_x = {1'b0, b_l} - {1'b0, p_l}
              - {{LIMB{1'b0}}, rb_r};
  // No final borrow means the operand is >= p.
  assign bad  = !ra_x[LIMB] || !rb_x[LIMB];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= 1'b0;
      c_r       <= 1'b0;
      w_r       <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      t_r       <= '0;
      u_r       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      ra_r      <= 1'b0;
      rb_r      <= 1'b0;
      err_range <= 1'b0;
`endif
    end else if (accept) begin
      state     <= CALC;
      cnt       <= '0;
      op_r      <= op;
      c_r       <= 1'b0;
      w_r       <= 1'b0;
      a_r       <= a;
      b_r       <= b;
      p_r       <= p;
      out_valid <= 1'b0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
      ra_r      <= 1'b0;
      rb_r      <= 1'b0;
      err_range <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        CALC: begin
          a_r <= a_sh;
          b_r <= b_sh;
          p_r <= p_sh;
          t_r <= t_nxt;
          u_r <= u_nxt;
          c_r <= t_x[LIMB];
          w_r <= u_x[LIMB];
          cnt <= cnt + 1'b1;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
          ra_r <= ra_x[LIMB];
          rb_r <= rb_x[LIMB];
`endif
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
            err_range <= bad;
            result    <= bad ? '0
                       : (sel_u ? u_nxt : t_nxt);
`else
            result    <= sel_u ? u_nxt : t_nxt;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Randomised self-checking bench for mod_addsub_serial against an
// arithmetic reference model; second instance covers LIMB == WIDTH.
module tb_mod_addsub_serial;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, op, out_valid, out_ready;
  logic [W-1:0] a, b, p, result;
  logic         in_valid1, in_ready1, op1, out_valid1, out_ready1;
  logic [W-1:0] a1, b1, p1, result1;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic         err_range, err_range1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_addsub_serial #(.WIDTH(W), .LIMB(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .p(p),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    , .err_range(err_range)
`endif
  );

  mod_addsub_serial #(.WIDTH(W), .LIMB(W)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .a(a1), .b(b1), .p(p1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    , .err_range(err_range1)
`endif
  );

  function automatic logic [W-1:0] ref_model(
    input bit o, input logic [W-1:0] x, y, m);
    logic [W:0] s;
    if (!o) begin
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (x >= y) begin
      s = {1'b0, x} - {1'b0, y};
    end else begin
      s = {1'b0, x} + {1'b0, m} - {1'b0, y};
    end
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one operation; lat counts edges from accept to out_valid.
  task automatic do_op(input bit which, input bit o,
                       input logic [W-1:0] x, y, m,
                       output logic [W-1:0] r, output int lat);
    int n;
    @(negedge clk);
    if (which) begin
      in_valid1 = 1; op1 = o; a1 = x; b1 = y; p1 = m;
      out_ready1 = 1;
    end else begin
      in_valid = 1; op = o; a = x; b = y; p = m;
      out_ready = 1;
    end
    n = 0;
    while (!(which ? in_ready1 : in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_valid1 = 0;
    lat = 0;
    while (!(which ? out_valid1 : out_valid) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = which ? result1 : result;
    if (lat >= 50) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 0; op = 0; a = '0; b = '0; p = '0; out_ready = 0;
    in_valid1 = 0; op1 = 0; a1 = '0; b1 = '0; p1 = '0;
    out_ready1 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (result !== '0 || result1 !== '0) begin
      errors++;
      $display("FAIL reset_result got %h/%h want 0", result, result1);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add_sub();
    bit            o[6]  = '{0, 0, 0, 1, 1, 1};
    int            xa[6] = '{10, 90, 50, 10, 20, 33};
    int            xb[6] = '{20, 20, 47, 20, 10, 33};
    int            ex[6] = '{30, 13, 0, 87, 10, 0};
    logic [W-1:0]  r, e;
    int            lat;
    for (int i = 0; i < 6; i++) begin
      do_op(0, o[i], W'(xa[i]), W'(xb[i]), W'(97), r, lat);
      e = W'(ex[i]);
      checks++;
      if (r !== e || lat != 4) begin
        errors++;
        $display("FAIL addsub_%0d got %0d lat %0d want %0d lat 4",
                 i, r, lat, e);
      end
    end
  endtask

  task automatic test_carry_path();
    logic [W-1:0] pb, r, e;
    int           lat;
    pb = '1;
    pb = pb - W'(188);
    e  = pb - W'(2);
    do_op(0, 0, pb - W'(1), pb - W'(1), pb, r, lat);
    checks++;
    if (r !== e || lat != 4) begin
      errors++;
      $display("FAIL carry_nl4 got %h lat %0d want %h lat 4",
               r, lat, e);
    end
    do_op(1, 0, pb - W'(1), pb - W'(1), pb, r, lat);
    checks++;
    if (r !== e || lat != 1) begin
      errors++;
      $display("FAIL carry_nl1 got %h lat %0d want %h lat 1",
               r, lat, e);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m, x, y, r, e;
    bit           o;
    int           lat, want;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) m = W'($urandom_range(1, 1000));
      else m = rand_w();
      if (m == '0) m = W'(1);
      x = rand_w() % m;
      y = rand_w() % m;
      if (i % 5 == 0) y = x;
      if (i % 7 == 1) x = m - x - W'(1);
      o = 1'($urandom_range(0, 1));
      e = ref_model(o, x, y, m);
      want = (i % 2 == 1) ? 1 : 4;
      do_op(i % 2 == 1, o, x, y, m, r, lat);
      checks++;
      if (r !== e || lat != want) begin
        errors++;
        $display("FAIL random_%0d op %0d got %h lat %0d want %h lat %0d",
                 i, o, r, lat, e, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int           lat;
    @(negedge clk);
    in_valid = 1; op = 0; a = W'(1); b = W'(2); p = W'(97);
    out_ready = 0;
    @(posedge clk);
    #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 4 || result !== W'(3)) begin
      errors++;
      $display("FAIL bp_first got %0d lat %0d want 3 lat 4",
               result, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1 || result !== W'(3) || in_ready !== 0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v%b r%0d rdy%b want v1 r3 rdy0",
                 i, out_valid, result, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1;
    in_valid = 1; op = 0; a = W'(40); b = W'(70); p = W'(97);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop_valid got %b want 0", out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = ref_model(0, W'(40), W'(70), W'(97));
    checks++;
    if (lat != 4 || result !== e) begin
      errors++;
      $display("FAIL bp_second got %0d lat %0d want %0d lat 4",
               result, lat, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r;
    int           lat;
    @(negedge clk);
    in_valid = 1; op = 0; a = W'(30); b = W'(40); p = W'(97);
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || result !== '0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid got v%b r%0d rdy%b want v0 r0 rdy1",
               out_valid, result, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    do_op(0, 0, W'(5), W'(6), W'(7), r, lat);
    checks++;
    if (r !== W'(4) || lat != 4) begin
      errors++;
      $display("FAIL after_reset got %0d lat %0d want 4 lat 4", r, lat);
    end
  endtask

  task automatic test_range();
    logic [W-1:0] r;
    int           lat;
    do_op(0, 0, W'(100), W'(5), W'(97), r, lat);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    checks++;
    if (r !== '0 || err_range !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL range_err got r%0d e%b lat %0d want r0 e1 lat 4",
               r, err_range, lat);
    end
    do_op(0, 1, W'(3), W'(5), W'(97), r, lat);
    checks++;
    if (r !== W'(95) || err_range !== 1'b0) begin
      errors++;
      $display("FAIL range_clear got r%0d e%b want r95 e0",
               r, err_range);
    end
`else
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL range_nohang got lat %0d want 4", lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_carry_path();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
- Limb-serial modular adder/subtractor for the Lagrange-interpolation TSS datapath. Computes (a + b) mod p or (a − b) mod p over a parametrised WIDTH.
- Processes LIMB bits per cycle so that wide 256-bit+ fields close timing.
- Uses valid/ready handshakes on input and output so it chains directly with mod_mul and accumulator stages.

Parameters:
- WIDTH, 256, operand/modulus/result width in bits; must be a multiple of LIMB.
- LIMB, 64, bits processed per cycle. Derived localparam NLIMB = WIDTH/LIMB (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands
- op  in  1  0 = add, 1 = subtract
- a  in  WIDTH  operand a, precondition a < p
- b  in  WIDTH  operand b, precondition b < p
- p  in  WIDTH  modulus, precondition p ≥ 1
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  (a op b) mod p

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, all internal registers 0. in_ready=1 during and after reset.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept when in_valid && in_ready:
  - latch a, b, p, op; clear limb counter, carry and borrow flags.
  - go to CALC.
  - if accepted from DONE, out_valid drops on the same edge.
- CALC, one limb per cycle, LSB limb first, for NLIMB cycles. Two chains run in parallel:
  - add: T = a+b with carry c; U = T−p with borrow w.
  - sub: T = a−b with borrow c; U = T+p with carry w (carry discarded).
  - limbs of T and U shift into WIDTH-bit registers; carry/borrow flags persist across limbs.
- Final selection, on the last CALC edge:
  - add: result = (c_out || !w_out) ? U : T (a+b ≥ p).
  - sub: result = c_out ? U : T (a < b).
  - selection uses the combinational final-limb values; result is registered.
  - state → DONE, out_valid=1.
- Latency: out_valid rises NLIMB cycles after the accepting edge (4 at defaults). Sustained throughput is one op per NLIMB+1 cycles.
- DONE:
  - result and out_valid held stable until out_ready=1.
  - on the handshake edge, go to IDLE, or to CALC if a new input is accepted on that same edge.
  - out_valid deasserts unless the new op completes (never in the same cycle).
- Width rule: all internal limb arithmetic uses LIMB+1 bits. No WIDTH+1 wide adder is permitted.
- Boundaries:
  - a+b == p gives 0.
  - a == b in sub gives 0.
  - a=b=p−1 at p near 2^WIDTH must take the carry-out path and give p−2.
  - NLIMB==1 must work (single CALC cycle).
- Out-of-precondition inputs (a or b ≥ p) give an unspecified but deterministic result. The block must not hang.
- Reset asserted mid-CALC or in DONE: operation discarded, outputs return to reset values immediately.
- Inputs a/b/p/op are ignored except on the accepting edge.

Optional Feature:
- MOD_ADDSUB_RANGE_CHK_EN.
- Defined:
  - adds output port err_range (1 bit, reset 0).
  - two extra serial borrow chains evaluate a−p and b−p during CALC.
  - if either has no final borrow (operand ≥ p), result is forced to 0 and err_range=1, both presented with out_valid.
  - err_range is cleared on the next accept.
- Undefined: port absent, no extra chains, behaviour as above.

Test Plan:
- WIDTH=256, p=97, op=0, a=10, b=20 -> result=30, out_valid exactly 4 cycles after accept.
- p=97, op=0: a=90, b=20 -> 13; a=50, b=47 -> 0.
- p=97, op=1: a=10, b=20 -> 87; a=20, b=10 -> 10; a=b=33 -> 0.
- p=2^256−189, op=0, a=b=p−1 -> p−2 (carry-out path). Repeat with LIMB=256 (NLIMB=1) -> same value at 1-cycle latency.
- Backpressure and back-to-back:
  - hold out_ready=0 for 5 cycles: result/out_valid stable, in_ready=0.
  - then out_ready=1 with next in_valid=1: accepted on the same edge, next result after 4 cycles.
- Reset:
  - rst_n pulsed low mid-CALC: out_valid=0, result=0, in_ready=1 at once.
  - next op 5+6 mod 7 -> 4.
  - with MOD_ADDSUB_RANGE_CHK_EN, a=100, p=97 -> result=0, err_range=1.
